stm_gain_loader: RTL and testbench

Writes STM gain-mode patterns into the STM BRAM from a valid/ready stream of per-transducer (intensity, phase) pairs. It is the producer on the BRAM side of the gain-mode STM path. It lays out data in the same segment/pattern/transducer address map that the `stm` gain reader consumes, so a loaded segment can be selected and played back directly. It sits between the host-side packet decoder and the STM memory write port.

---
 rtl/params.sv | 45 ++++
 rtl/stm_gain_addr_gen.sv | 75 +++++++
 rtl/stm_gain_loader.sv | 174 +++++++++++++++++
 tb/tb_stm_gain_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/params.sv
// -----------------------------------------------------------------------------
// params
//   Shared definitions for the gain-mode STM path. The STM gain reader and the
//   loader both build BRAM addresses through stm_gain_addr(), so the
//   {segment, pattern, transducer index} layout lives in exactly one place.
//
//   Contents:
//     STM_GAIN_IDX_WIDTH      transducer index field width (256 slots/pattern)
//     STM_GAIN_PATTERN_WIDTH  default pattern index width
//     loader_state_t          loader FSM states (IDLE, LOAD)
//     stm_gain_addr_width()   total address width for a given pattern width
//     stm_gain_addr()         packs {seg, pat, idx}; pattern widths up to 16
// -----------------------------------------------------------------------------
package params;

  localparam int STM_GAIN_IDX_WIDTH     = 8;
  localparam int STM_GAIN_PATTERN_WIDTH = 13;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } loader_state_t;

  // One segment bit on top, pattern in the middle, transducer index at the bottom.
  function automatic int stm_gain_addr_width(input int pattern_width);
    return 1 + pattern_width + STM_GAIN_IDX_WIDTH;
  endfunction

  // Returned right-aligned in 32 bits; callers truncate to
  // stm_gain_addr_width(pattern_width). The pattern argument must already be
  // limited to pattern_width bits (zero-extended to 16).
  function automatic logic [31:0] stm_gain_addr(
    input logic        seg,
    input logic [15:0] pat,
    input logic [7:0]  idx,
    input int          pattern_width
  );
    logic [31:0] addr;
    addr = (32'(seg) << (pattern_width + STM_GAIN_IDX_WIDTH))
         | (32'(pat) << STM_GAIN_IDX_WIDTH)
         | 32'(idx);
    return addr;
  endfunction

endpackage

// File: rtl/stm_gain_addr_gen.sv
// -----------------------------------------------------------------------------
// stm_gain_addr_gen
//   Pattern / transducer-index counters for the gain-mode STM loader.
//   idx runs 0..DEPTH-1; on wrap it returns to 0 and pat increments. Slots
//   DEPTH..255 of a pattern are therefore never addressed. 'last' flags the
//   final word of a load (pat == count, idx == DEPTH-1) combinationally from
//   the counter registers so the loader can act on it in the accepting cycle.
//
//   Ports:
//     CLK      system clock
//     RST      asynchronous active-high reset
//     clear    zero both counters (start of a load); wins over advance
//     advance  step to the next transducer slot (one accepted word)
//     count    index of the final pattern of this load
//     idx      current transducer index
//     pat      current pattern index
//     last     current slot is the final one of the load
// -----------------------------------------------------------------------------
module stm_gain_addr_gen
  import params::*;
#(
  parameter int DEPTH         = 249,
  parameter int PATTERN_WIDTH = STM_GAIN_PATTERN_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          clear,
  input  logic                          advance,
  input  logic [PATTERN_WIDTH-1:0]      count,
  output logic [STM_GAIN_IDX_WIDTH-1:0] idx,
  output logic [PATTERN_WIDTH-1:0]      pat,
  output logic                          last
);

  localparam logic [STM_GAIN_IDX_WIDTH-1:0] IDX_LAST = STM_GAIN_IDX_WIDTH'(DEPTH - 1);

  logic [STM_GAIN_IDX_WIDTH-1:0] idx_reg;
  logic [STM_GAIN_IDX_WIDTH-1:0] idx_next;
  logic [PATTERN_WIDTH-1:0]      pat_reg;
  logic [PATTERN_WIDTH-1:0]      pat_next;
  logic                          idx_at_end;

  assign idx_at_end = (idx_reg == IDX_LAST);

  always_comb begin
    idx_next = idx_reg;
    pat_next = pat_reg;
    if (clear) begin
      idx_next = '0;
      pat_next = '0;
    end else if (advance) begin
      if (idx_at_end) begin
        idx_next = '0;
        pat_next = pat_reg + 1'b1;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_reg <= '0;
      pat_reg <= '0;
    end else begin
      idx_reg <= idx_next;
      pat_reg <= pat_next;
    end
  end

  assign idx  = idx_reg;
  assign pat  = pat_reg;
  assign last = idx_at_end && (pat_reg == count);

endmodule

// File: rtl/stm_gain_loader.sv
// -----------------------------------------------------------------------------
// stm_gain_loader
//   Writes gain-mode STM patterns into the STM BRAM from a valid/ready stream
//   of (intensity, phase) pairs, using the same {segment, pattern, index}
//   layout the stm gain reader consumes.
//
//   START in IDLE latches SEGMENT and the pattern count (CYCLE clamped to
//   2^PATTERN_WIDTH-1) and enters LOAD. In LOAD every accepted word is
//   written one cycle later; the final word of the final pattern returns the
//   FSM to IDLE and pulses DONE alongside its write.
//
//   Parameters:
//     DEPTH          transducers per pattern (must be <= 256)
//     PATTERN_WIDTH  pattern index bits (must be <= 16)
//
//   Ports:
//     CLK        system clock
//     RST        asynchronous active-high reset
//     START      single-cycle load request (ignored while loading)
//     SEGMENT    target segment, sampled on an accepted START
//     CYCLE      number of patterns minus 1, sampled on an accepted START
//     DIN_VALID  stream word valid
//     DIN_READY  loader accepts a word this cycle (high in LOAD)
//     INTENSITY  transducer intensity
//     PHASE      transducer phase
//     BRAM_WE    STM memory write enable
//     BRAM_ADDR  {segment, pattern, transducer index}
//     BRAM_DIN   {intensity, phase}
//     BUSY       a load is in progress
//     DONE       one-cycle pulse with the final write
//     CHECKSUM   mod-2^16 sum of BRAM_DIN over the last load
//
//   Build option:
//     STM_GAIN_LOADER_CHECKSUM_EN  when defined, CHECKSUM is a running sum
//                                  cleared on START; otherwise tied to 0.
// -----------------------------------------------------------------------------
module stm_gain_loader
  import params::*;
#(
  parameter  int DEPTH         = 249,
  parameter  int PATTERN_WIDTH = STM_GAIN_PATTERN_WIDTH,
  localparam int ADDR_WIDTH    = stm_gain_addr_width(PATTERN_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SEGMENT,
  input  logic [15:0]           CYCLE,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  input  logic [7:0]            INTENSITY,
  input  logic [7:0]            PHASE,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [15:0]           BRAM_DIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [15:0]           CHECKSUM
);

  localparam logic [PATTERN_WIDTH-1:0] COUNT_MAX = '1;

  loader_state_t                 state_reg;
  logic                          seg_reg;
  logic [PATTERN_WIDTH-1:0]      count_reg;
  logic                          we_reg;
  logic [ADDR_WIDTH-1:0]         addr_reg;
  logic [15:0]                   din_reg;
  logic                          done_reg;

  logic                          start_accept;
  logic                          word_accept;
  logic [PATTERN_WIDTH-1:0]      count_next;
  logic [STM_GAIN_IDX_WIDTH-1:0] idx;
  logic [PATTERN_WIDTH-1:0]      pat;
  logic                          last_word;
  logic [ADDR_WIDTH-1:0]         addr_next;
  logic [15:0]                   word;

  assign start_accept = START && (state_reg == IDLE);
  assign word_accept  = DIN_VALID && (state_reg == LOAD);
  assign word         = {INTENSITY, PHASE};

  // Requests beyond what the pattern field can address saturate to the
  // largest pattern index instead of wrapping.
  always_comb begin
    count_next = PATTERN_WIDTH'(CYCLE);
    if (32'(CYCLE) > 32'(COUNT_MAX)) begin
      count_next = COUNT_MAX;
    end
  end

  stm_gain_addr_gen #(
    .DEPTH         (DEPTH),
    .PATTERN_WIDTH (PATTERN_WIDTH)
  ) u_addr_gen (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (start_accept),
    .advance (word_accept),
    .count   (count_reg),
    .idx     (idx),
    .pat     (pat),
    .last    (last_word)
  );

  assign addr_next = ADDR_WIDTH'(stm_gain_addr(seg_reg, 16'(pat), idx, PATTERN_WIDTH));

  // FSM and registered write port. BRAM_WE/DONE default low each cycle so a
  // write is presented for exactly one cycle after its word is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      seg_reg   <= 1'b0;
      count_reg <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      din_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            seg_reg   <= SEGMENT;
            count_reg <= count_next;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (DIN_VALID) begin
            we_reg   <= 1'b1;
            addr_reg <= addr_next;
            din_reg  <= word;
            done_reg <= last_word;
            if (last_word) begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign DIN_READY = (state_reg == LOAD);
  assign BUSY      = (state_reg == LOAD);
  assign BRAM_WE   = we_reg;
  assign BRAM_ADDR = addr_reg;
  assign BRAM_DIN  = din_reg;
  assign DONE      = done_reg;

`ifdef STM_GAIN_LOADER_CHECKSUM_EN
  // Summing at accept time means the total including the final word is
  // registered in the same cycle DONE is presented.
  logic [15:0] checksum_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      checksum_reg <= '0;
    end else if (start_accept) begin
      checksum_reg <= '0;
    end else if (word_accept) begin
      checksum_reg <= checksum_reg + word;
    end
  end

  assign CHECKSUM = checksum_reg;
`else
  assign CHECKSUM = 16'h0000;
`endif

endmodule

// File: tb/tb_stm_gain_loader.sv
// -----------------------------------------------------------------------------
// tb_stm_gain_loader
//   Scoreboard bench for stm_gain_loader. The driver pushes one expected
//   {done, addr, din} per accepted word; a negedge monitor pops and compares
//   every BRAM write. PATTERN_WIDTH is reduced to 4 so the CYCLE clamp case
//   (16 patterns) stays short.
// -----------------------------------------------------------------------------
module tb_stm_gain_loader;

  localparam int DEPTH = 249;
  localparam int PW    = 4;
  localparam int AW    = 1 + PW + 8;
  localparam int PMAX  = (1 << PW) - 1;

`ifdef STM_GAIN_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          SEGMENT = 1'b0;
  logic [15:0]   CYCLE = 16'h0;
  logic          DIN_VALID = 1'b0;
  logic          DIN_READY;
  logic [7:0]    INTENSITY = 8'h0;
  logic [7:0]    PHASE = 8'h0;
  logic          BRAM_WE;
  logic [AW-1:0] BRAM_ADDR;
  logic [15:0]   BRAM_DIN;
  logic          BUSY;
  logic          DONE;
  logic [15:0]   CHECKSUM;

  stm_gain_loader #(
    .DEPTH         (DEPTH),
    .PATTERN_WIDTH (PW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .SEGMENT   (SEGMENT),
    .CYCLE     (CYCLE),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .INTENSITY (INTENSITY),
    .PHASE     (PHASE),
    .BRAM_WE   (BRAM_WE),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_DIN  (BRAM_DIN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CHECKSUM  (CHECKSUM)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          done;
    logic [AW-1:0] addr;
    logic [15:0]   din;
  } wr_t;

  wr_t           exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            wr_cnt   = 0;
  int            busy_cnt = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each presented write against the scoreboard head.
  always @(negedge CLK) begin
    if (BUSY) busy_cnt++;
    if (BRAM_WE) begin
      wr_cnt++;
      last_addr = BRAM_ADDR;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h din 0x%0h, expected no write", BRAM_ADDR, BRAM_DIN);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(BRAM_ADDR), 32'(e.addr));
        check("write_din",  32'(BRAM_DIN),  32'(e.din));
        check("write_done", 32'(DONE),      32'(e.done));
      end
    end else begin
      check("done_without_write", 32'(DONE), 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    32'(DIN_READY), 32'd0);
    check({tag, "_we"},       32'(BRAM_WE),   32'd0);
    check({tag, "_addr"},     32'(BRAM_ADDR), 32'd0);
    check({tag, "_din"},      32'(BRAM_DIN),  32'd0);
    check({tag, "_busy"},     32'(BUSY),      32'd0);
    check({tag, "_done"},     32'(DONE),      32'd0);
    check({tag, "_checksum"}, 32'(CHECKSUM),  32'd0);
  endtask

  // One load. mode: 0 = structured data, 1 = random, 2 = all 0xFF.
  // start_at / rst_at: word index at which to pulse START / assert RST (-1 = never).
  task automatic do_load(input logic seg, input logic [15:0] cyc, input int mode,
                         input bit gaps, input int start_at, input int rst_at,
                         output int busy_cycles);
    int          cnt;
    int          k;
    int          wr0;
    int          busy0;
    logic [15:0] sum;
    logic [15:0] d;
    wr_t         e;
    cnt   = (int'(cyc) > PMAX) ? PMAX : int'(cyc);
    k     = 0;
    sum   = 16'h0;
    wr0   = wr_cnt;
    busy0 = busy_cnt;
    busy_cycles = 0;

    SEGMENT = seg;
    CYCLE   = cyc;
    START   = 1'b1;
    @(posedge CLK); #1;
    START   = 1'b0;
    // Scramble the sampled inputs: the latched values must be used from now on.
    SEGMENT = ~seg;
    CYCLE   = 16'($urandom);
    check("ready_after_start",    32'(DIN_READY), 32'd1);
    check("busy_after_start",     32'(BUSY),      32'd1);
    check("checksum_clear_start", 32'(CHECKSUM),  32'd0);

    for (int p = 0; p <= cnt; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (k == rst_at) begin
          DIN_VALID = 1'b0;
          RST = 1'b1;
          #1;
          check_reset_outputs("midload_reset");
          exp_q.delete();   // the write presented this cycle never reaches memory
          @(posedge CLK); #1;
          RST = 1'b0;
          $display("load seg=%0d cycle=0x%0h reset after %0d words", seg, cyc, k);
          return;
        end
        if (gaps && ($urandom_range(0, 2) == 0)) begin
          DIN_VALID = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            INTENSITY = 8'($urandom);
            PHASE     = 8'($urandom);
            @(posedge CLK); #1;
          end
        end
        case (mode)
          0:       d = {8'(i) ^ 8'(p * 17), ~8'(i)};
          1:       d = 16'($urandom);
          default: d = 16'hFFFF;
        endcase
        INTENSITY = d[15:8];
        PHASE     = d[7:0];
        DIN_VALID = 1'b1;
        if (k == start_at) begin
          START   = 1'b1;
          SEGMENT = 1'b0;
          CYCLE   = 16'd7;
        end
        check("ready_in_load", 32'(DIN_READY), 32'd1);
        e.done = (p == cnt) && (i == DEPTH - 1);
        e.addr = {seg, PW'(p), 8'(i)};
        e.din  = d;
        exp_q.push_back(e);
        sum = sum + d;
        @(posedge CLK); #1;
        START = 1'b0;
        k++;
      end
    end
    DIN_VALID = 1'b0;

    // Cycle after the final accept: DONE with the last write, FSM back in IDLE.
    check("busy_after_last",  32'(BUSY),      32'd0);
    check("ready_after_last", 32'(DIN_READY), 32'd0);
    check("done_at_last",     32'(DONE),      32'd1);
    check("checksum_at_done", 32'(CHECKSUM),  CK_EN ? 32'(sum) : 32'd0);
    @(posedge CLK); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("write_count",        32'(wr_cnt - wr0), 32'((cnt + 1) * DEPTH));
    busy_cycles = busy_cnt - busy0;
    $display("load seg=%0d cycle=0x%0h patterns=%0d writes=%0d busy=%0d checksum=0x%04h",
             seg, cyc, cnt + 1, wr_cnt - wr0, busy_cycles, CHECKSUM);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int wr0;

    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;
    @(posedge CLK); #1;

    // Single pattern, back-to-back words: 0x000..0x0F8, BUSY for DEPTH cycles.
    do_load(1'b0, 16'd0, 0, 1'b0, -1, -1, busy);
    check("busy_cycles_single", 32'(busy), 32'(DEPTH));

    // Four patterns into segment 1 with random data and valid gaps.
    do_load(1'b1, 16'd3, 1, 1'b1, -1, -1, busy);

    // START (SEGMENT=0, CYCLE=7) mid-load is ignored.
    do_load(1'b1, 16'd1, 0, 1'b0, 100, -1, busy);
    check("busy_cycles_ignored_start", 32'(busy), 32'(2 * DEPTH));

    // Reset after 100 accepted words, then a fresh load restarts at idx 0.
    do_load(1'b0, 16'd2, 1, 1'b0, -1, 100, busy);
    do_load(1'b0, 16'd0, 1, 1'b1, -1, -1, busy);

    // CYCLE beyond the pattern field clamps to the last pattern index.
    do_load(1'b1, 16'hFFFF, 1, 1'b0, -1, -1, busy);
    check("clamp_last_addr", 32'(last_addr), 32'h1FF8);

    // All-ones words over one pattern: 249 * 0xFFFF mod 2^16 = 0xFF07.
    do_load(1'b0, 16'd0, 2, 1'b0, -1, -1, busy);
    repeat (2) @(posedge CLK);
    #1;
    check("checksum_hold", 32'(CHECKSUM), CK_EN ? 32'hFF07 : 32'h0);

    // DIN_VALID in IDLE must not be accepted.
    wr0 = wr_cnt;
    DIN_VALID = 1'b1;
    INTENSITY = 8'hA5;
    PHASE     = 8'h5A;
    repeat (4) begin
      check("ready_in_idle", 32'(DIN_READY), 32'd0);
      @(posedge CLK); #1;
    end
    DIN_VALID = 1'b0;
    @(posedge CLK); #1;
    check("no_write_in_idle", 32'(wr_cnt - wr0), 32'd0);
    $display("idle valid: writes=%0d", wr_cnt - wr0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
